clock_gate_ctrl: RTL and testbench

Idle-detection controller that drives the enable input of the integrated clock-gating cell in front of a BNN compute unit.
- Counts consecutive idle cycles of the unit.
- Runs a sleep-request/acknowledge handshake so the unit quiesces before its clock is gated.
- Re-enables the clock on new work, then signals when the unit may accept it.
- Runs on the ungated clock; one instance per gated domain.

---
 rtl/bnn_cg_pkg.sv | 13 +
 rtl/cg_sat_counter.sv | 39 +++
 rtl/clock_gate_ctrl.sv | 150 +++++++++++++++
 tb/tb_clock_gate_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bnn_cg_pkg.sv
// Shared types for the BNN clock-gate controller: FSM state encoding.
package bnn_cg_pkg;

    localparam int CG_STATE_W = 2;

    typedef enum logic [CG_STATE_W-1:0] {
        ACTIVE    = 2'd0,
        SLEEP_REQ = 2'd1,
        GATED     = 2'd2,
        WAKE      = 2'd3
    } cg_state_e;

endpackage

// File: rtl/cg_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX once reached.
module cg_sat_counter #(
    parameter int unsigned W       = 4,
    parameter logic [W-1:0] MAX    = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: clear wins over increment, increment stops at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/clock_gate_ctrl.sv
// Idle-detect / sleep-handshake controller driving a clock-gate enable.
// Optional statistics counters are built when CLOCK_GATE_STATS_EN is defined.
module clock_gate_ctrl
    import bnn_cg_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned STAT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  busy,
    input  logic                  req_valid,
    input  logic                  sleep_ack,
    input  logic                  force_on,
    output logic                  gate_en,
    output logic                  sleep_req,
    output logic                  wake_ready,
    output logic [CG_STATE_W-1:0] state
`ifdef CLOCK_GATE_STATS_EN
    ,
    output logic [STAT_W-1:0]     gated_cycles,
    output logic [STAT_W-1:0]     gate_events
`endif
);

    localparam int unsigned IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int unsigned WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_MAX = WAKE_W'(WAKE_CYCLES - 1);

    if (IDLE_CYCLES < 1) begin : g_bad_idle
        $error("clock_gate_ctrl: IDLE_CYCLES must be >= 1");
    end
    if (WAKE_CYCLES < 1) begin : g_bad_wake
        $error("clock_gate_ctrl: WAKE_CYCLES must be >= 1");
    end

    cg_state_e         state_d, state_q;
    logic [WAKE_W-1:0] wake_cnt_d, wake_cnt_q;
    logic              gate_en_d, gate_en_q;
    logic              sleep_req_d, sleep_req_q;
    logic              wake_ready_d, wake_ready_q;
    logic [IDLE_W-1:0] idle_cnt_s;
    logic              idle_s;
    logic              idle_inc_s;

    assign idle_s     = !busy && !req_valid && !force_on;
    // Idle run only accumulates in ACTIVE; every other state leaves it at zero.
    assign idle_inc_s = (state_q == ACTIVE) && idle_s;

    cg_sat_counter #(.W(IDLE_W), .MAX(IDLE_MAX)) u_idle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (idle_inc_s),
        .clr   (!idle_inc_s),
        .cnt   (idle_cnt_s)
    );

    // Next-state, wake counter and Moore output decode.
    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ACTIVE: begin
                if (idle_s && (idle_cnt_s == IDLE_MAX)) begin
                    state_d = SLEEP_REQ;
                end else begin
                    state_d = ACTIVE;
                end
            end
            SLEEP_REQ: begin
                if (!idle_s) begin
                    state_d = ACTIVE;
                end else if (sleep_ack) begin
                    state_d = GATED;
                end else begin
                    state_d = SLEEP_REQ;
                end
            end
            GATED: begin
                if (req_valid || force_on) begin
                    state_d    = WAKE;
                    wake_cnt_d = '0;
                end else begin
                    state_d = GATED;
                end
            end
            WAKE: begin
                if (wake_cnt_q == WAKE_MAX) begin
                    state_d = ACTIVE;
                end else begin
                    wake_cnt_d = wake_cnt_q + WAKE_W'(1);
                end
            end
            default: begin
                state_d = ACTIVE;
            end
        endcase

        case (state_d)
            ACTIVE:    {gate_en_d, sleep_req_d, wake_ready_d} = 3'b101;
            SLEEP_REQ: {gate_en_d, sleep_req_d, wake_ready_d} = 3'b110;
            GATED:     {gate_en_d, sleep_req_d, wake_ready_d} = 3'b000;
            WAKE:      {gate_en_d, sleep_req_d, wake_ready_d} = 3'b100;
            default:   {gate_en_d, sleep_req_d, wake_ready_d} = 3'b101;
        endcase
    end

    // State and registered outputs; reset lands in ACTIVE with the clock on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ACTIVE;
            wake_cnt_q   <= '0;
            gate_en_q    <= 1'b1;
            sleep_req_q  <= 1'b0;
            wake_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            wake_cnt_q   <= wake_cnt_d;
            gate_en_q    <= gate_en_d;
            sleep_req_q  <= sleep_req_d;
            wake_ready_q <= wake_ready_d;
        end
    end

    assign gate_en    = gate_en_q;
    assign sleep_req  = sleep_req_q;
    assign wake_ready = wake_ready_q;
    assign state      = state_q;

`ifdef CLOCK_GATE_STATS_EN
    cg_sat_counter #(.W(STAT_W), .MAX({STAT_W{1'b1}})) u_gated_cycles (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (state_q == GATED),
        .clr   (1'b0),
        .cnt   (gated_cycles)
    );

    cg_sat_counter #(.W(STAT_W), .MAX({STAT_W{1'b1}})) u_gate_events (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state_q == SLEEP_REQ) && idle_s && sleep_ack),
        .clr   (1'b0),
        .cnt   (gate_events)
    );
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed self-checking bench for clock_gate_ctrl (IDLE_CYCLES=4, WAKE_CYCLES=2).
// Statistics checks are compiled when CLOCK_GATE_STATS_EN is defined.
module tb_clock_gate_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic        req_valid;
    logic        sleep_ack;
    logic        force_on;
    logic        gate_en;
    logic        sleep_req;
    logic        wake_ready;
    logic [1:0]  state;
`ifdef CLOCK_GATE_STATS_EN
    logic [31:0] gated_cycles;
    logic [31:0] gate_events;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clock_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2), .STAT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .busy       (busy),
        .req_valid  (req_valid),
        .sleep_ack  (sleep_ack),
        .force_on   (force_on),
        .gate_en    (gate_en),
        .sleep_req  (sleep_req),
        .wake_ready (wake_ready),
        .state      (state)
`ifdef CLOCK_GATE_STATS_EN
        ,
        .gated_cycles (gated_cycles),
        .gate_events  (gate_events)
`endif
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the full Moore output set for one expected state.
    task automatic chk_out(input string tag, input logic [1:0] st, input logic ge,
                           input logic sr, input logic wr);
        chk({tag, ".state"},      {30'd0, state},     {30'd0, st});
        chk({tag, ".gate_en"},    {31'd0, gate_en},   {31'd0, ge});
        chk({tag, ".sleep_req"},  {31'd0, sleep_req}, {31'd0, sr});
        chk({tag, ".wake_ready"}, {31'd0, wake_ready},{31'd0, wr});
    endtask

    initial begin
        rst_n = 1'b0; busy = 1'b0; req_valid = 1'b0; sleep_ack = 1'b0; force_on = 1'b0;
        tick(2);
        chk_out("reset", 2'd0, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b1;

        // Four idle cycles from reset reach SLEEP_REQ on the fourth edge.
        tick(3);
        chk_out("idle3", 2'd0, 1'b1, 1'b0, 1'b1);
        tick(1);
        chk_out("idle4", 2'd1, 1'b1, 1'b1, 1'b0);

        // Holding without ack stays in SLEEP_REQ; busy aborts back to ACTIVE.
        tick(1);
        chk_out("sreq_hold", 2'd1, 1'b1, 1'b1, 1'b0);
        busy = 1'b1;
        tick(1);
        chk_out("sreq_abort", 2'd0, 1'b1, 1'b0, 1'b1);
        busy = 1'b0;

        // Idle run broken by one busy cycle restarts the count.
        tick(3);
        busy = 1'b1;
        tick(1);
        chk_out("break_busy", 2'd0, 1'b1, 1'b0, 1'b1);
        busy = 1'b0;
        tick(3);
        chk_out("restart3", 2'd0, 1'b1, 1'b0, 1'b1);
        tick(1);
        chk_out("restart4", 2'd1, 1'b1, 1'b1, 1'b0);

        // Abort beats sleep_ack in the same cycle.
        req_valid = 1'b1; sleep_ack = 1'b1;
        tick(1);
        chk_out("abort_wins", 2'd0, 1'b1, 1'b0, 1'b1);
        req_valid = 1'b0; sleep_ack = 1'b0;

        // Enter GATED; busy and sleep_ack are ignored there.
        tick(4);
        sleep_ack = 1'b1;
        tick(1);
        chk_out("gated", 2'd2, 1'b0, 1'b0, 1'b0);
        busy = 1'b1;
        tick(1);
        chk_out("gated_busy", 2'd2, 1'b0, 1'b0, 1'b0);
        busy = 1'b0; sleep_ack = 1'b0;

        // One-cycle req_valid: gate_en at t+1, wake_ready at t+3.
        req_valid = 1'b1;
        tick(1);
        chk_out("wake_t1", 2'd3, 1'b1, 1'b0, 1'b0);
        req_valid = 1'b0;
        tick(1);
        chk_out("wake_t2", 2'd3, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_out("wake_t3", 2'd0, 1'b1, 1'b0, 1'b1);

        // Reset while gated returns straight to ACTIVE with the clock on.
        tick(4);
        sleep_ack = 1'b1;
        tick(1);
        sleep_ack = 1'b0;
        chk_out("gated2", 2'd2, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick(1);
        chk_out("rst_in_gated", 2'd0, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b1;
`ifdef CLOCK_GATE_STATS_EN
        chk("stat_rst_cycles", gated_cycles, 32'd0);
        chk("stat_rst_events", gate_events, 32'd0);
`endif

        // force_on keeps the controller out of sleep.
        force_on = 1'b1;
        tick(8);
        chk_out("force_on", 2'd0, 1'b1, 1'b0, 1'b1);
        force_on = 1'b0;

        // Gate for ten cycles, then wake.
        tick(4);
        sleep_ack = 1'b1;
        tick(1);
        sleep_ack = 1'b0;
        chk_out("gated3", 2'd2, 1'b0, 1'b0, 1'b0);
        tick(9);
        req_valid = 1'b1;
        tick(1);
        req_valid = 1'b0;
        chk_out("wake3", 2'd3, 1'b1, 1'b0, 1'b0);
`ifdef CLOCK_GATE_STATS_EN
        chk("stat_cycles10", gated_cycles, 32'd10);
        chk("stat_events1", gate_events, 32'd1);
`endif
        tick(2);
        chk_out("active3", 2'd0, 1'b1, 1'b0, 1'b1);

        // Second sleep, woken by force_on.
        tick(4);
        sleep_ack = 1'b1;
        tick(1);
        sleep_ack = 1'b0;
        chk_out("gated4", 2'd2, 1'b0, 1'b0, 1'b0);
        force_on = 1'b1;
        tick(1);
        chk_out("force_wake", 2'd3, 1'b1, 1'b0, 1'b0);
`ifdef CLOCK_GATE_STATS_EN
        chk("stat_cycles11", gated_cycles, 32'd11);
        chk("stat_events2", gate_events, 32'd2);
`endif
        tick(2);
        chk_out("active4", 2'd0, 1'b1, 1'b0, 1'b1);
        force_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
